// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor built around one
// full-subtractor cell. It processes one bit per clock, LSB first, under a
// start/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request, sampled only while ready=1
//   a, b       minuend / subtrahend, captured on the accepting edge
//   borrow_in  initial borrow, captured on the accepting edge
//   ready      high in IDLE only (registered)
//   valid      one-cycle pulse when the result is published (registered)
//   diff       a - b - borrow_in mod 2^WIDTH (registered, held until next result)
//   borrow_out final borrow, i.e. unsigned a < b + borrow_in (registered)
//   overflow   signed overflow of the subtraction (registered)
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned RES_W = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state, state_d;
  logic               ready_d, valid_d;
  logic [WIDTH-1:0]   a_sr, b_sr;
  logic [RES_W-1:0]   res_sr;
  logic               br;
  logic [CNT_W-1:0]   cnt;

  logic               a_bit, b_bit, d_bit, br_next, last_bit;

  // Full-subtractor cell on the current operand LSBs and running borrow.
  assign a_bit    = a_sr[0];
  assign b_bit    = b_sr[0];
  assign d_bit    = a_bit ^ b_bit ^ br;
  assign br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // Next-state and next-output logic.
  always_comb begin
    state_d = state;
    ready_d = 1'b0;
    valid_d = 1'b0;
    case (state)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    valid_d = (state_d == DONE);
  end

  // State and handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ready <= 1'b1;
      valid <= 1'b0;
    end else begin
      state <= state_d;
      ready <= ready_d;
      valid <= valid_d;
    end
  end

  // Operand/result shift registers, counter and published results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            br     <= borrow_in;
            res_sr <= '0;
            cnt    <= '0;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          // New difference bit enters at the top; the oldest bit drops off
          // only after it has been published.
          res_sr <= RES_W'({d_bit, res_sr} >> 1);
          br     <= br_next;
          if (!last_bit) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            // On the last bit the operand LSBs are the captured MSBs.
            diff       <= {d_bit, res_sr};
            borrow_out <= br_next;
            overflow   <= (a_bit ^ b_bit) & (d_bit ^ a_bit);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and exhaustive bench for serial_subtractor.
// An 8-bit instance is checked every cycle against an arithmetic model;
// a 4-bit instance is swept over all operand/borrow combinations.
module tb_serial_subtractor;

  localparam int unsigned W8 = 8;
  localparam int unsigned W4 = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic          start = 1'b0;
  logic [W8-1:0] a = '0, b = '0;
  logic          bin = 1'b0;
  logic          ready, valid, bo, ov;
  logic [W8-1:0] diff;

  logic          start4 = 1'b0;
  logic [W4-1:0] a4 = '0, b4 = '0;
  logic          bin4 = 1'b0;
  logic          ready4, valid4, bo4, ov4;
  logic [W4-1:0] diff4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .borrow_in(bin),
    .ready(ready), .valid(valid), .diff(diff), .borrow_out(bo), .overflow(ov)
  );

  serial_subtractor #(.WIDTH(W4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .borrow_in(bin4),
    .ready(ready4), .valid(valid4), .diff(diff4), .borrow_out(bo4), .overflow(ov4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic on plain integers.
  function automatic longint f_diff(input int w, input longint x, input longint y, input longint bi);
    longint m, r;
    m = longint'(1) << w;
    r = x - y - bi;
    return (r < 0) ? r + m : r;
  endfunction

  function automatic longint f_bo(input int w, input longint x, input longint y, input longint bi);
    return (x - y - bi < 0) ? 1 : 0;
  endfunction

  function automatic longint f_ov(input int w, input longint x, input longint y, input longint bi);
    longint m, sx, sy, sr;
    m  = longint'(1) << w;
    sx = (x >= m / 2) ? x - m : x;
    sy = (y >= m / 2) ? y - m : y;
    sr = sx - sy - bi;
    return (sr < -(m / 2) || sr > m / 2 - 1) ? 1 : 0;
  endfunction

  // Cycle model of the 8-bit instance: acceptance, W-cycle latency, hold.
  logic          m_ready = 1'b1, m_valid = 1'b0, m_bo = 1'b0, m_ov = 1'b0;
  logic [W8-1:0] m_diff = '0;
  int            m_left = 0;
  longint        pa = 0, pb = 0, pbin = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready <= 1'b1;
      m_valid <= 1'b0;
      m_left  <= 0;
      m_diff  <= '0;
      m_bo    <= 1'b0;
      m_ov    <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      if (m_ready) begin
        if (start) begin
          m_ready <= 1'b0;
          m_left  <= W8 + 1;
          pa      <= longint'(a);
          pb      <= longint'(b);
          pbin    <= longint'(bin);
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 2) begin
          m_diff  <= W8'(f_diff(W8, pa, pb, pbin));
          m_bo    <= 1'(f_bo(W8, pa, pb, pbin));
          m_ov    <= 1'(f_ov(W8, pa, pb, pbin));
          m_valid <= 1'b1;
        end
        if (m_left == 1) m_ready <= 1'b1;
      end
    end
  end

  // Per-cycle comparison of the 8-bit instance against the model.
  always @(negedge clk) begin
    if ($time > 6) begin
      chk("ready8", ready, m_ready);
      chk("valid8", valid, m_valid);
      chk("diff8",  diff,  m_diff);
      chk("bo8",    bo,    m_bo);
      chk("ov8",    ov,    m_ov);
    end
  end

  task automatic wait_ready8();
    int found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) begin found = 1; break; end
    end
    if (found == 0) chk("ready8_wait", 0, 1);
  endtask

  task automatic do_op8(input string name, input logic [7:0] xa, input logic [7:0] xb,
                        input logic xbi, input logic [7:0] ed, input logic ebo, input logic eov);
    int lat = -1;
    wait_ready8();
    start = 1'b1; a = xa; b = xb; bin = xbi;
    @(posedge clk);
    #1;
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (valid) begin lat = i - 1; break; end
    end
    chk({name, "_latency"}, lat, 8);
    chk({name, "_diff"}, diff, ed);
    chk({name, "_bo"}, bo, ebo);
    chk({name, "_ov"}, ov, eov);
    @(negedge clk);
    chk({name, "_pulse"}, valid, 0);
  endtask

  task automatic do_op4(input int xa, input int xb, input int xbi);
    int lat = -1;
    int found = 0;
    for (int i = 0; i < 40; i++) begin
      if (ready4) begin found = 1; break; end
      @(negedge clk);
    end
    if (found == 0) chk("ready4_wait", 0, 1);
    start4 = 1'b1; a4 = 4'(xa); b4 = 4'(xb); bin4 = 1'(xbi);
    @(posedge clk);
    #1;
    start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (valid4) begin lat = i - 1; break; end
    end
    chk("w4_latency", lat, 4);
    chk("w4_diff", diff4, f_diff(W4, xa, xb, xbi));
    chk("w4_bo",   bo4,   f_bo(W4, xa, xb, xbi));
    chk("w4_ov",   ov4,   f_ov(W4, xa, xb, xbi));
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int last = -1;
    int n_acc = 0;

    // Hand-computed values that pin the reference functions.
    chk("pin_diff_05_03", f_diff(8, 5, 3, 0), 2);
    chk("pin_diff_03_05", f_diff(8, 3, 5, 0), 8'hFE);
    chk("pin_bo_03_05",   f_bo(8, 3, 5, 0), 1);
    chk("pin_ov_80_01",   f_ov(8, 8'h80, 1, 0), 1);
    chk("pin_ov_7f_ff",   f_ov(8, 8'h7F, 8'hFF, 0), 1);
    chk("pin_diff_00_b1", f_diff(8, 0, 0, 1), 8'hFF);
    chk("pin_ov_00_b1",   f_ov(8, 0, 0, 1), 0);

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_valid", valid, 0);
    chk("rst_diff",  diff,  0);
    chk("rst_bo",    bo,    0);
    chk("rst_ov",    ov,    0);
    #2 rst_n = 1'b1;

    // Directed vectors.
    do_op8("basic",     8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    do_op8("underflow", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    do_op8("ovf_neg",   8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    do_op8("ovf_pos",   8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    do_op8("borrowin",  8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    do_op8("ff_ff_b1",  8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

    // Start held high with a changing every cycle.
    wait_ready8();
    start = 1'b1; b = 8'h21; bin = 1'b0;
    for (int i = 0; i < 40; i++) begin
      a = 8'(i * 13 + 7);
      if (ready) begin
        if (last >= 0) chk("accept_spacing", i - last, 10);
        last = i;
        n_acc++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("accept_count", n_acc, 4);

    // Reset in the middle of an operation (bit 4 in flight).
    wait_ready8();
    start = 1'b1; a = 8'h5A; b = 8'h33; bin = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", ready, 1);
    chk("midrst_valid", valid, 0);
    chk("midrst_diff",  diff,  0);
    chk("midrst_bo",    bo,    0);
    chk("midrst_ov",    ov,    0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    do_op8("after_rst", 8'h5A, 8'h33, 1'b0, 8'h27, 1'b0, 1'b0);

    // Exhaustive sweep of the 4-bit instance.
    @(negedge clk);
    for (int xa = 0; xa < 16; xa++)
      for (int xb = 0; xb < 16; xb++)
        for (int xbi = 0; xbi < 2; xbi++)
          do_op4(xa, xb, xbi);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
